// File: rtl/symbol_packer.sv
// Packs BITS_PER_SYM-bit symbols into OUT_WIDTH-bit words behind a small FIFO.
// Define SYMBOL_PACKER_LSB_FIRST_EN for LSB-first packing (default MSB-first).
module symbol_packer #(
    parameter int MODULATION_ORDER = 16,
    parameter int OUT_WIDTH        = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_dv,
    input  logic [$clog2(MODULATION_ORDER)-1:0] i_symbol,
    input  logic                                i_last,
    output logic                                o_dv,
    output logic [OUT_WIDTH-1:0]                o_word,
    output logic                                o_last,
    input  logic                                i_ready,
    output logic                                o_overflow
);
    localparam int BPS   = $clog2(MODULATION_ORDER);
    localparam int ACC_W = OUT_WIDTH + BPS;
    localparam int CW    = $clog2(ACC_W) + 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] OUT_C = CW'(OUT_WIDTH);
    localparam logic [CW-1:0] BPS_C = CW'(BPS);

    typedef enum logic {PACK, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [OUT_WIDTH-1:0] mem_word_q [FIFO_DEPTH];
    logic                 mem_last_q [FIFO_DEPTH];

    logic [ACC_W-1:0]     acc_app, rem_app;
    logic [CW-1:0]        cnt_app;
    logic [OUT_WIDTH-1:0] word_app, flush_word, push_word;
    logic                 push, push_last, do_push, pop, full;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_word = '0;
        push_last = 1'b0;
        cnt_app   = cnt_q + BPS_C;
`ifdef SYMBOL_PACKER_LSB_FIRST_EN
        acc_app    = acc_q | (ACC_W'(i_symbol) << cnt_q);
        word_app   = acc_app[OUT_WIDTH-1:0];
        rem_app    = acc_app >> OUT_WIDTH;
        flush_word = acc_q[OUT_WIDTH-1:0];
`else
        // Bits are kept right-aligned; the oldest cnt bits sit just below bit cnt.
        acc_app    = (acc_q << BPS) | ACC_W'(i_symbol);
        word_app   = OUT_WIDTH'(acc_app >> (cnt_app - OUT_C));
        rem_app    = acc_app & ~({ACC_W{1'b1}} << (cnt_app - OUT_C));
        flush_word = OUT_WIDTH'(acc_q << (OUT_C - cnt_q));
`endif
        if (state_q == FLUSH) begin
            push      = 1'b1;
            push_word = flush_word;
            push_last = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = PACK;
            if (i_dv) ovf_d = 1'b1;
        end else if (i_dv) begin
            if (cnt_app >= OUT_C) begin
                push      = 1'b1;
                push_word = word_app;
                push_last = i_last && (cnt_app == OUT_C);
                acc_d     = rem_app;
                cnt_d     = cnt_app - OUT_C;
            end else begin
                acc_d = acc_app;
                cnt_d = cnt_app;
            end
            if (i_last && (cnt_d != '0)) state_d = FLUSH;
        end
        pop     = o_dv && i_ready;
        full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
        do_push = push && (!full || pop);
        if (push && !do_push) ovf_d = 1'b1;
        wr_d = wr_q + (PW+1)'(do_push);
        rd_d = rd_q + (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PACK;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_word_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            if (do_push) begin
                mem_word_q[wr_q[PW-1:0]] <= push_word;
                mem_last_q[wr_q[PW-1:0]] <= push_last;
            end
        end
    end

    assign o_dv       = (wr_q != rd_q);
    assign o_word     = mem_word_q[rd_q[PW-1:0]];
    assign o_last     = mem_last_q[rd_q[PW-1:0]];
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: M=16 and M=64 instances, both packing orders.
module tb_symbol_packer;
`ifdef SYMBOL_PACKER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       dv16, last16, rdy16;
    logic [3:0] sym16;
    logic       odv16, olast16, ovf16;
    logic [7:0] word16;
    logic       dv64, last64, rdy64;
    logic [5:0] sym64;
    logic       odv64, olast64, ovf64;
    logic [7:0] word64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    symbol_packer #(.MODULATION_ORDER(16), .OUT_WIDTH(8), .FIFO_DEPTH(4)) u_dut16 (
        .clk(clk), .rst(rst), .i_dv(dv16), .i_symbol(sym16), .i_last(last16),
        .o_dv(odv16), .o_word(word16), .o_last(olast16), .i_ready(rdy16),
        .o_overflow(ovf16));

    symbol_packer #(.MODULATION_ORDER(64), .OUT_WIDTH(8), .FIFO_DEPTH(4)) u_dut64 (
        .clk(clk), .rst(rst), .i_dv(dv64), .i_symbol(sym64), .i_last(last64),
        .o_dv(odv64), .o_word(word64), .o_last(olast64), .i_ready(rdy64),
        .o_overflow(ovf64));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick(input logic [7:0] msb, input logic [7:0] lsb);
        return LSB ? lsb : msb;
    endfunction

    task automatic send16(input logic [3:0] s, input logic l);
        dv16 = 1'b1; sym16 = s; last16 = l;
        tick();
        dv16 = 1'b0; last16 = 1'b0;
    endtask

    task automatic send64(input logic [5:0] s, input logic l);
        dv64 = 1'b1; sym64 = s; last64 = l;
        tick();
        dv64 = 1'b0; last64 = 1'b0;
    endtask

    logic [7:0] bp_exp [4];

    initial begin
        rst = 1'b1;
        dv16 = 0; sym16 = 0; last16 = 0; rdy16 = 1;
        dv64 = 0; sym64 = 0; last64 = 0; rdy64 = 1;
        tick(); tick();
        check("rst_dv", odv16, 0);
        check("rst_word", word16, 0);
        check("rst_last", olast16, 0);
        check("rst_ovf", ovf16, 0);
        rst = 1'b0;

        // two symbols -> one word, visible the cycle after the second symbol
        send16(4'hA, 0);
        check("t1_dv_early", odv16, 0);
        send16(4'h5, 0);
        check("t1_dv", odv16, 1);
        check("t1_word", word16, pick(8'hA5, 8'h5A));
        check("t1_last", olast16, 0);
        tick();
        check("t1_popped", odv16, 0);

        // odd symbol count with last -> full word then padded flush word
        send16(4'h3, 0);
        send16(4'hC, 0);
        check("t2_w0", word16, pick(8'h3C, 8'hC3));
        check("t2_w0_last", olast16, 0);
        send16(4'h7, 1);
        check("t2_flush_dv", odv16, 0);
        tick();
        check("t2_w1_dv", odv16, 1);
        check("t2_w1", word16, pick(8'h70, 8'h07));
        check("t2_w1_last", olast16, 1);
        tick();
        check("t2_empty", odv16, 0);
        check("t2_ovf", ovf16, 0);

        // single symbol with last -> flush only
        send16(4'h3, 1);
        check("t3_dv", odv16, 0);
        tick();
        check("t3_word", word16, pick(8'h30, 8'h03));
        check("t3_last", olast16, 1);
        tick();

        // M=64: words straddle symbol boundaries
        send64(6'h3F, 0);
        send64(6'h00, 0);
        check("m64_w0", word64, pick(8'hFC, 8'h3F));
        check("m64_w0_last", olast64, 0);
        send64(6'h3F, 0);
        check("m64_w1", word64, pick(8'h0F, 8'hF0));
        send64(6'h00, 1);
        check("m64_w2", word64, pick(8'hC0, 8'h03));
        check("m64_w2_last", olast64, 1);
        tick();
        check("m64_empty", odv64, 0);
        check("m64_ovf", ovf64, 0);

        // symbol during FLUSH is dropped and flagged
        send16(4'h9, 1);
        send16(4'h5, 0);
        check("t4_ovf", ovf16, 1);
        check("t4_flush", word16, pick(8'h90, 8'h09));
        tick();
        send16(4'h6, 0);
        send16(4'h7, 0);
        check("t4_next", word16, pick(8'h67, 8'h76));
        tick();

        // backpressure: fifth word dropped
        rst = 1'b1; tick(); rst = 1'b0;
        rdy16 = 1'b0;
        for (int i = 1; i <= 10; i++) send16(4'(i), 0);
        check("bp_ovf", ovf16, 1);
        bp_exp[0] = pick(8'h12, 8'h21);
        bp_exp[1] = pick(8'h34, 8'h43);
        bp_exp[2] = pick(8'h56, 8'h65);
        bp_exp[3] = pick(8'h78, 8'h87);
        tick();
        check("bp_hold", word16, bp_exp[0]);
        rdy16 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_dv%0d", k), odv16, 1);
            check($sformatf("bp_w%0d", k), word16, bp_exp[k]);
            tick();
        end
        check("bp_empty", odv16, 0);
        check("bp_ovf_sticky", ovf16, 1);

        // reset mid-word discards the partial symbol
        send16(4'hF, 0);
        rst = 1'b1;
        tick();
        check("rm_dv", odv16, 0);
        check("rm_ovf", ovf16, 0);
        rst = 1'b0;
        send16(4'h1, 0);
        check("rm_dv_early", odv16, 0);
        send16(4'h2, 0);
        check("rm_word", word16, pick(8'h12, 8'h21));
        check("rm_dv", odv16, 1);
        tick();
        check("rm_single", odv16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
